// File: rtl/inst_encoder.sv
// RV32I instruction assembler with LI (LUI/ADDI) expansion and range/alignment checking.
// Latency 1 cycle; one registered output slot, input stalls while the slot is held or an ADDI is pending.
module inst_encoder #(
   parameter logic [31:0] NOP_WORD = 32'h00000013
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [2:0]  in_fmt,
   input  logic [6:0]  in_opcode,
   input  logic [2:0]  in_funct3,
   input  logic [6:0]  in_funct7,
   input  logic [4:0]  in_rd,
   input  logic [4:0]  in_rs1,
   input  logic [4:0]  in_rs2,
   input  logic [31:0] in_imm,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_instr,
   output logic        out_err,
   output logic        out_last
);

   localparam logic [2:0] FMT_I  = 3'd0;
   localparam logic [2:0] FMT_SH = 3'd1;
   localparam logic [2:0] FMT_S  = 3'd2;
   localparam logic [2:0] FMT_B  = 3'd3;
   localparam logic [2:0] FMT_U  = 3'd4;
   localparam logic [2:0] FMT_J  = 3'd5;
   localparam logic [2:0] FMT_LI = 3'd6;

   localparam logic [6:0] OP_LUI  = 7'h37;
   localparam logic [6:0] OP_ADDI = 7'h13;

   typedef enum logic {IDLE, LI2} state_t;

   state_t      state, state_nxt;
   logic [31:0] pend_word;

   logic        load_en;
   logic        accept;
   logic [31:0] enc_instr;
   logic        enc_err;
   logic        enc_two;
   logic [31:0] enc_word2;

   logic        imm12_ok;
   logic        imm13_ok;
   logic        imm21_ok;
   logic [19:0] li_hi;

   assign load_en  = !out_valid || out_ready;
   assign in_ready = (state == IDLE) && load_en;
   assign accept   = in_valid && in_ready;

   // Sign-extension checks: the bits above the field width must all match.
   assign imm12_ok = (&in_imm[31:11]) || !(|in_imm[31:11]);
   assign imm13_ok = (&in_imm[31:12]) || !(|in_imm[31:12]);
   assign imm21_ok = (&in_imm[31:20]) || !(|in_imm[31:20]);

   // (imm + 0x800) >> 12: the +0x800 carries into bit 12 exactly when imm[11] is set.
   assign li_hi = in_imm[31:12] + {19'd0, in_imm[11]};

   always_comb begin
      enc_instr = NOP_WORD;
      enc_err   = 1'b0;
      enc_two   = 1'b0;
      enc_word2 = NOP_WORD;
      case (in_fmt)
         FMT_I: begin
            if (imm12_ok)
               enc_instr = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
            else
               enc_err = 1'b1;
         end
         FMT_SH: begin
            if (!(|in_imm[31:5]))
               enc_instr = {in_funct7, in_imm[4:0], in_rs1, in_funct3, in_rd, in_opcode};
            else
               enc_err = 1'b1;
         end
         FMT_S: begin
            if (imm12_ok)
               enc_instr = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
            else
               enc_err = 1'b1;
         end
         FMT_B: begin
            if (imm13_ok && !in_imm[0])
               enc_instr = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                            in_imm[4:1], in_imm[11], in_opcode};
            else
               enc_err = 1'b1;
         end
         FMT_U: begin
            if (!(|in_imm[11:0]))
               enc_instr = {in_imm[31:12], in_rd, in_opcode};
            else
               enc_err = 1'b1;
         end
         FMT_J: begin
            if (imm21_ok && !in_imm[0])
               enc_instr = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
            else
               enc_err = 1'b1;
         end
         FMT_LI: begin
            if (imm12_ok) begin
               enc_instr = {in_imm[11:0], 5'd0, 3'b000, in_rd, OP_ADDI};
            end else begin
               enc_instr = {li_hi, in_rd, OP_LUI};
               if (|in_imm[11:0]) begin
                  enc_two   = 1'b1;
                  enc_word2 = {in_imm[11:0], in_rd, 3'b000, in_rd, OP_ADDI};
               end
            end
         end
         default: enc_err = 1'b1;
      endcase
   end

   always_comb begin
      state_nxt = state;
      if (load_en) begin
         if (state == LI2)
            state_nxt = IDLE;
         else if (accept && enc_two)
            state_nxt = LI2;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         out_valid <= 1'b0;
         out_instr <= 32'd0;
         out_err   <= 1'b0;
         out_last  <= 1'b0;
         pend_word <= 32'd0;
      end else begin
         state <= state_nxt;
         if (load_en) begin
            if (state == LI2) begin
               out_valid <= 1'b1;
               out_instr <= pend_word;
               out_err   <= 1'b0;
               out_last  <= 1'b1;
            end else if (accept) begin
               out_valid <= 1'b1;
               out_instr <= enc_instr;
               out_err   <= enc_err;
               out_last  <= !enc_two;
               pend_word <= enc_word2;
            end else begin
               out_valid <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_inst_encoder.sv
// Directed bench for inst_encoder: hand-computed encodings, range boundaries, LI split, backpressure, reset.
module tb_inst_encoder;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  in_fmt;
   logic [6:0]  in_opcode;
   logic [2:0]  in_funct3;
   logic [6:0]  in_funct7;
   logic [4:0]  in_rd;
   logic [4:0]  in_rs1;
   logic [4:0]  in_rs2;
   logic [31:0] in_imm;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic        out_err;
   logic        out_last;

   int checks   = 0;
   int failures = 0;

   localparam logic [31:0] NOP = 32'h00000013;

   inst_encoder dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_fmt    (in_fmt),
      .in_opcode (in_opcode),
      .in_funct3 (in_funct3),
      .in_funct7 (in_funct7),
      .in_rd     (in_rd),
      .in_rs1    (in_rs1),
      .in_rs2    (in_rs2),
      .in_imm    (in_imm),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_instr (out_instr),
      .out_err   (out_err),
      .out_last  (out_last)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Present one request; returns #1 after the accepting edge.
   task automatic req(input logic [2:0] fmt, input logic [6:0] op, input logic [2:0] f3,
                      input logic [6:0] f7, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [31:0] imm);
      int n;
      @(negedge clk);
      in_fmt = fmt; in_opcode = op; in_funct3 = f3; in_funct7 = f7;
      in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
      in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (n == 20) chk("req_timeout", {31'd0, in_ready}, 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic expw(input string tag, input logic [31:0] instr, input logic err, input logic last);
      chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
      chk({tag, "_instr"}, out_instr, instr);
      chk({tag, "_err"},   {31'd0, out_err}, {31'd0, err});
      chk({tag, "_last"},  {31'd0, out_last}, {31'd0, last});
   endtask

   initial begin
      reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      in_fmt = 3'd0; in_opcode = 7'd0; in_funct3 = 3'd0; in_funct7 = 7'd0;
      in_rd = 5'd0; in_rs1 = 5'd0; in_rs2 = 5'd0; in_imm = 32'd0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_instr", out_instr, 32'd0);
      chk("rst_err",   {31'd0, out_err}, 32'd0);
      chk("rst_last",  {31'd0, out_last}, 32'd0);
      reset = 1'b0;
      @(posedge clk); #1;
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

      // Basic formats
      req(3'd0, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'hFFFFFFFF);
      expw("i_neg1", 32'hFFF00093, 1'b0, 1'b1);
      req(3'd3, 7'h63, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'd8);
      expw("b_8", 32'h00208463, 1'b0, 1'b1);
      req(3'd3, 7'h63, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'd3);
      expw("b_odd", NOP, 1'b1, 1'b1);
      req(3'd3, 7'h63, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'd4094);
      expw("b_max", 32'h7E208FE3, 1'b0, 1'b1);
      req(3'd3, 7'h63, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'd4096);
      expw("b_over", NOP, 1'b1, 1'b1);
      req(3'd2, 7'h23, 3'd2, 7'd0, 5'd0, 5'd2, 5'd3, 32'hFFFFFFFC);
      expw("s_neg4", 32'hFE312E23, 1'b0, 1'b1);
      req(3'd1, 7'h13, 3'd5, 7'h20, 5'd5, 5'd6, 5'd0, 32'd3);
      expw("srai", 32'h40335293, 1'b0, 1'b1);
      req(3'd1, 7'h13, 3'd1, 7'h00, 5'd5, 5'd6, 5'd0, 32'd32);
      expw("sh_over", NOP, 1'b1, 1'b1);
      req(3'd0, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd2048);
      expw("i_over", NOP, 1'b1, 1'b1);
      req(3'd4, 7'h37, 3'd0, 7'd0, 5'd10, 5'd0, 5'd0, 32'hABCDE000);
      expw("u", 32'hABCDE537, 1'b0, 1'b1);
      req(3'd4, 7'h37, 3'd0, 7'd0, 5'd10, 5'd0, 5'd0, 32'h00000123);
      expw("u_low", NOP, 1'b1, 1'b1);
      req(3'd5, 7'h6F, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'hFFFFFFFC);
      expw("j_neg4", 32'hFFDFF0EF, 1'b0, 1'b1);
      req(3'd7, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd0);
      expw("fmt7", NOP, 1'b1, 1'b1);

      // LI single-word forms
      req(3'd6, 7'd0, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h00001000);
      expw("li_lui", 32'h000012B7, 1'b0, 1'b1);
      req(3'd6, 7'd0, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h000007FF);
      expw("li_7ff", 32'h7FF00293, 1'b0, 1'b1);
      req(3'd6, 7'd0, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'hFFFFF800);
      expw("li_m2048", 32'h80000293, 1'b0, 1'b1);
      req(3'd6, 7'd0, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h80000000);
      expw("li_min", 32'h800002B7, 1'b0, 1'b1);

      // LI two-word form, free-flowing
      req(3'd6, 7'd0, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h12345FFF);
      expw("li2_w1", 32'h123462B7, 1'b0, 1'b0);
      chk("li2_in_ready", {31'd0, in_ready}, 32'd0);
      @(posedge clk); #1;
      expw("li2_w2", 32'hFFF28293, 1'b0, 1'b1);
      @(posedge clk); #1;
      chk("li2_drained", {31'd0, out_valid}, 32'd0);

      // LI two-word form under backpressure
      out_ready = 1'b0;
      req(3'd6, 7'd0, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h12345FFF);
      expw("bp_w1", 32'h123462B7, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         chk("bp_hold_instr", out_instr, 32'h123462B7);
         chk("bp_hold_last", {31'd0, out_last}, 32'd0);
         chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      expw("bp_w2", 32'hFFF28293, 1'b0, 1'b1);
      @(posedge clk); #1;
      chk("bp_drained", {31'd0, out_valid}, 32'd0);

      // Reset while the ADDI is pending
      out_ready = 1'b0;
      req(3'd6, 7'd0, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h12345FFF);
      expw("rl_w1", 32'h123462B7, 1'b0, 1'b0);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      out_ready = 1'b1;
      chk("rl_valid", {31'd0, out_valid}, 32'd0);
      chk("rl_in_ready", {31'd0, in_ready}, 32'd1);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         chk("rl_no_addi", {31'd0, out_valid}, 32'd0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
